ahb_mst_arb: RTL and testbench

- Round-robin arbiter that shares the single-transfer AHB master request interface among NUM_MST requesters.
- Requesters are the UART debug bridge and future DMA/CPU agents.
- Sits between the requesters and the AHB master interface block; locks the grant for one transfer and routes Okay back to the owner.
- Includes a per-transfer watchdog so a hung slave cannot starve the other requesters.

---
 rtl/ahb_mst_arb.sv | 136 +++++++++++++
 tb/tb_ahb_mst_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mst_arb.sv
// Round-robin arbiter sharing one single-transfer AHB master port among NUM_MST requesters.
// Grant is held for one transfer; a watchdog releases the bus with MstErr if Okay never arrives.
module ahb_mst_arb #(
   parameter int NUM_MST  = 2,
   parameter int TOUT_CYC = 255,
   parameter int TOUT_W   = 16
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [NUM_MST-1:0]      MstReq,
   input  logic [NUM_MST-1:0]      MstWrite,
   input  logic [3*NUM_MST-1:0]    MstSize,
   input  logic [32*NUM_MST-1:0]   MstAddr,
   input  logic [32*NUM_MST-1:0]   MstOut,
   output logic [NUM_MST-1:0]      MstOkay,
   output logic [NUM_MST-1:0]      MstErr,
   output logic [NUM_MST-1:0]      MstGnt,
   output logic [31:0]             MstIn,
   output logic                    AhbReq,
   output logic                    AhbBurst,
   output logic                    AhbBusy,
   output logic                    AhbWrite,
   output logic [2:0]              AhbSize,
   output logic [31:0]             AhbAddr,
   output logic [31:0]             AhbOut,
   input  logic [31:0]             AhbIn,
   input  logic                    Okay
);

   localparam int IDW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
   localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ERR   = 2'd2
   } state_t;

   state_t            state, stateNxt;
   logic [IDW-1:0]    GntId, GntIdNxt;
   logic [IDW-1:0]    RrPtr, RrPtrNxt;
   logic [IDW-1:0]    PickId, NextPtr;
   logic [IDW:0]      cand;
   logic              PickVld;
   logic              ownReq;
   logic [TOUT_W-1:0] wdog, wdogNxt;

   assign MstIn    = AhbIn;
   assign AhbBurst = 1'b0;
   assign AhbBusy  = 1'b0;
   assign ownReq   = MstReq[GntId];
   assign NextPtr  = (GntId == IDW'(NUM_MST - 1)) ? '0 : GntId + 1'b1;

   // First requester at or after RrPtr, wrapping modulo NUM_MST (need not be a power of two).
   always_comb begin
      PickVld = 1'b0;
      PickId  = '0;
      cand    = '0;
      for (int k = 0; k < NUM_MST; k++) begin
         cand = {1'b0, RrPtr} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NUM_MST))
            cand = cand - (IDW+1)'(NUM_MST);
         if (!PickVld && MstReq[cand[IDW-1:0]]) begin
            PickVld = 1'b1;
            PickId  = cand[IDW-1:0];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         GntId <= '0;
         RrPtr <= '0;
         wdog  <= '0;
      end else begin
         state <= stateNxt;
         GntId <= GntIdNxt;
         RrPtr <= RrPtrNxt;
         wdog  <= wdogNxt;
      end
   end

   always_comb begin
      stateNxt = state;
      GntIdNxt = GntId;
      RrPtrNxt = RrPtr;
      wdogNxt  = wdog;
      MstOkay  = '0;
      MstErr   = '0;
      MstGnt   = '0;
      AhbReq   = 1'b0;
      AhbWrite = 1'b0;
      AhbSize  = '0;
      AhbAddr  = '0;
      AhbOut   = '0;
      case (state)
         IDLE: begin
            wdogNxt = '0;
            if (PickVld) begin
               GntIdNxt = PickId;
               stateNxt = GRANT;
            end
         end
         GRANT: begin
            wdogNxt = wdog + 1'b1;
            AhbReq  = ownReq & ~Okay;
            for (int i = 0; i < NUM_MST; i++) begin
               if (GntId == IDW'(i)) begin
                  MstGnt[i]  = 1'b1;
                  MstOkay[i] = Okay;
                  AhbWrite   = MstWrite[i];
                  AhbSize    = MstSize[3*i +: 3];
                  AhbAddr    = MstAddr[32*i +: 32];
                  AhbOut     = MstOut[32*i +: 32];
               end
            end
            // Completion beats abort and timeout; abort beats timeout.
            if (Okay || !ownReq) begin
               stateNxt = IDLE;
               RrPtrNxt = NextPtr;
            end else if (wdog == TOUT_LAST) begin
               stateNxt = ERR;
            end
         end
         ERR: begin
            for (int i = 0; i < NUM_MST; i++)
               MstErr[i] = (GntId == IDW'(i));
            stateNxt = IDLE;
            RrPtrNxt = NextPtr;
         end
         default: stateNxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ahb_mst_arb.sv
// Directed bench for ahb_mst_arb (2 requesters, 8-cycle watchdog) with a grant scoreboard.
module tb_ahb_mst_arb;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [1:0]  MstReq, MstWrite;
   logic [5:0]  MstSize;
   logic [63:0] MstAddr, MstOut;
   logic [1:0]  MstOkay, MstErr, MstGnt;
   logic [31:0] MstIn;
   logic        AhbReq, AhbBurst, AhbBusy, AhbWrite;
   logic [2:0]  AhbSize;
   logic [31:0] AhbAddr, AhbOut, AhbIn;
   logic        Okay;

   ahb_mst_arb #(.NUM_MST(2), .TOUT_CYC(8), .TOUT_W(16)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .MstReq(MstReq), .MstWrite(MstWrite), .MstSize(MstSize),
      .MstAddr(MstAddr), .MstOut(MstOut),
      .MstOkay(MstOkay), .MstErr(MstErr), .MstGnt(MstGnt), .MstIn(MstIn),
      .AhbReq(AhbReq), .AhbBurst(AhbBurst), .AhbBusy(AhbBusy),
      .AhbWrite(AhbWrite), .AhbSize(AhbSize), .AhbAddr(AhbAddr), .AhbOut(AhbOut),
      .AhbIn(AhbIn), .Okay(Okay)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          id;
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] data;
   } xfer_t;

   xfer_t       sbq[$];
   int          nChecks = 0;
   int          nErrors = 0;
   int          rr = 0;
   int          id, prevId;
   logic [31:0] addrT [2] = '{32'h1000_0000, 32'h2000_0040};
   logic        wrT   [2] = '{1'b1, 1'b0};
   logic [2:0]  szT   [2] = '{3'd2, 3'd1};
   logic [31:0] datT  [2] = '{32'hA5A5_0001, 32'h5A5A_0002};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge CLK);
      #2;
   endtask

   function automatic int pick(input int p, input logic [1:0] req);
      for (int k = 0; k < 2; k++) begin
         if (req[(p + k) % 2]) return (p + k) % 2;
      end
      return 0;
   endfunction

   task automatic push(input int pid);
      xfer_t e;
      e.id = pid; e.addr = addrT[pid]; e.wr = wrT[pid];
      e.size = szT[pid]; e.data = datT[pid];
      sbq.push_back(e);
   endtask

   // Call in the first GRANT cycle: pops the expected owner and checks the muxed bus.
   task automatic grantChk(output int gid);
      xfer_t e;
      gid = 0;
      chk("sbq_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
         e = sbq.pop_front();
         gid = e.id;
         chk("gnt_ahbreq", 32'(AhbReq), 32'd1);
         chk("gnt_onehot", 32'(MstGnt), 32'd1 << e.id);
         chk("gnt_addr", AhbAddr, e.addr);
         chk("gnt_write", 32'(AhbWrite), 32'(e.wr));
         chk("gnt_size", 32'(AhbSize), 32'(e.size));
         chk("gnt_wdata", AhbOut, e.data);
      end
   endtask

   // Entered in an IDLE cycle; returns in the bubble IDLE cycle after Okay.
   task automatic xfer(input int waitCyc, output int gid);
      logic [31:0] rd;
      nxt();
      grantChk(gid);
      repeat (waitCyc) begin
         nxt();
         chk("wait_ahbreq", 32'(AhbReq), 32'd1);
         chk("wait_okay", 32'(MstOkay), 32'd0);
      end
      nxt();
      rd = $urandom;
      Okay = 1'b1; AhbIn = rd;
      #1;
      chk("okay_route", 32'(MstOkay), 32'd1 << gid);
      chk("okay_ahbreq_drop", 32'(AhbReq), 32'd0);
      chk("okay_no_err", 32'(MstErr), 32'd0);
      chk("okay_rdata", MstIn, rd);
      nxt();
      Okay = 1'b0;
      #1;
      chk("bubble_gnt", 32'(MstGnt), 32'd0);
      chk("bubble_ahbreq", 32'(AhbReq), 32'd0);
      chk("bubble_okay", 32'(MstOkay), 32'd0);
      chk("bubble_err", 32'(MstErr), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      RST_N = 1'b0; Okay = 1'b0; AhbIn = '0; MstReq = '0;
      MstWrite = {wrT[1], wrT[0]};
      MstSize  = {szT[1], szT[0]};
      MstAddr  = {addrT[1], addrT[0]};
      MstOut   = {datT[1], datT[0]};
      repeat (3) nxt();
      chk("rst_ahbreq", 32'(AhbReq), 32'd0);
      chk("rst_gnt", 32'(MstGnt), 32'd0);
      chk("rst_okay", 32'(MstOkay), 32'd0);
      chk("rst_err", 32'(MstErr), 32'd0);
      chk("rst_addr", AhbAddr, 32'd0);
      chk("rst_wdata", AhbOut, 32'd0);
      chk("rst_size", 32'(AhbSize), 32'd0);
      chk("rst_write", 32'(AhbWrite), 32'd0);
      chk("tie_burst_busy", 32'({AhbBurst, AhbBusy}), 32'd0);
      RST_N = 1'b1;
      nxt();

      // Single requester: AhbReq one cycle after Req, Okay on the 4th GRANT cycle.
      MstReq = 2'b01;
      #1;
      chk("lat_idle_ahbreq", 32'(AhbReq), 32'd0);
      push(pick(rr, MstReq));
      xfer(2, id);
      rr = (id + 1) % 2;
      MstReq = 2'b00;
      nxt();

      // Contention: both held, grants must alternate.
      MstReq = 2'b11;
      prevId = rr ^ 1;
      for (int g = 0; g < 4; g++) begin
         push(pick(rr, MstReq));
         xfer(1, id);
         chk("rr_alternate", 32'(id), 32'(prevId ^ 1));
         prevId = id;
         rr = (id + 1) % 2;
      end
      MstReq = 2'b00;
      nxt();

      // Watchdog: 8 GRANT cycles without Okay, then one ERR cycle.
      MstReq = 2'b01;
      nxt();
      chk("tout_gnt", 32'(MstGnt), 32'd1);
      for (int c = 2; c <= 8; c++) begin
         nxt();
         chk("tout_ahbreq", 32'(AhbReq), 32'd1);
         chk("tout_no_err", 32'(MstErr), 32'd0);
      end
      MstReq = 2'b11;
      nxt();
      #1;
      chk("tout_err", 32'(MstErr), 32'd1);
      chk("tout_err_ahbreq", 32'(AhbReq), 32'd0);
      chk("tout_err_addr", AhbAddr, 32'd0);
      chk("tout_err_okay", 32'(MstOkay), 32'd0);
      rr = 1;
      MstReq = 2'b10;
      nxt();
      chk("tout_err_pulse", 32'(MstErr), 32'd0);
      push(pick(rr, MstReq));
      xfer(0, id);
      rr = (id + 1) % 2;
      MstReq = 2'b00;
      nxt();

      // Okay exactly on the watchdog's last cycle wins over the timeout.
      MstReq = 2'b01;
      push(pick(rr, MstReq));
      xfer(6, id);
      rr = (id + 1) % 2;
      MstReq = 2'b00;
      nxt();

      // Abort: move pointer to 0 first, then owner 0 drops Req mid-GRANT.
      MstReq = 2'b10;
      push(pick(rr, MstReq));
      xfer(0, id);
      rr = (id + 1) % 2;
      MstReq = 2'b11;
      push(pick(rr, MstReq));
      nxt();
      grantChk(id);
      nxt();
      MstReq = 2'b10;
      #1;
      chk("abort_ahbreq", 32'(AhbReq), 32'd0);
      chk("abort_okay", 32'(MstOkay), 32'd0);
      nxt();
      chk("abort_idle_gnt", 32'(MstGnt), 32'd0);
      chk("abort_no_okay", 32'(MstOkay), 32'd0);
      chk("abort_no_err", 32'(MstErr), 32'd0);
      rr = (id + 1) % 2;
      MstReq = 2'b11;
      push(pick(rr, MstReq));
      xfer(1, id);
      rr = (id + 1) % 2;
      MstReq = 2'b00;
      nxt();

      // Reset mid-transfer with the pointer at 1; afterwards requester 0 must win.
      MstReq = 2'b01;
      push(pick(rr, MstReq));
      xfer(0, id);
      rr = (id + 1) % 2;
      MstReq = 2'b10;
      push(pick(rr, MstReq));
      nxt();
      grantChk(id);
      nxt();
      RST_N = 1'b0;
      #1;
      chk("mid_rst_ahbreq", 32'(AhbReq), 32'd0);
      chk("mid_rst_gnt", 32'(MstGnt), 32'd0);
      chk("mid_rst_addr", AhbAddr, 32'd0);
      chk("mid_rst_wdata", AhbOut, 32'd0);
      chk("mid_rst_write", 32'(AhbWrite), 32'd0);
      chk("mid_rst_size", 32'(AhbSize), 32'd0);
      MstReq = 2'b11;
      nxt();
      nxt();
      RST_N = 1'b1;
      rr = 0;
      push(pick(rr, MstReq));
      xfer(1, id);
      chk("post_rst_first", 32'(id), 32'd0);
      MstReq = 2'b00;
      nxt();

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
